dma_mem_responder: RTL and testbench

Synthesizable byte-wide memory target that answers the read/write requests issued by `tt_um_dma` on its external transfer bus. It is the responder end of the DMA bus: it latches each request, inserts a programmable number of wait states, commits or returns one data byte, and pulses an acknowledge. It serves as the on-die scratch memory for DMA loopback and as the bench target for DMA stall and error handling.

---
 rtl/dma_bus_pkg.sv | 19 +
 rtl/dma_mem_responder_if.sv | 31 +++
 rtl/dma_resp_mem.sv | 44 ++++
 rtl/dma_mem_responder.sv | 113 +++++++++++
 tb/tb_dma_mem_responder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dma_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_pkg
// Description : Shared DMA bus constants and responder FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_bus_pkg;

    localparam int DMA_BUS_W = 8;
    localparam logic [DMA_BUS_W-1:0] DMA_ERR_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        DMA_RESP_IDLE = 2'd0,
        DMA_RESP_WAIT = 2'd1,
        DMA_RESP_ACK  = 2'd2
    } dma_resp_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_mem_responder_if
// Description : DMA external transfer bus between initiator and responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_mem_responder_if;
    import dma_bus_pkg::*;

    logic                 bus_req;
    logic                 bus_we;
    logic [DMA_BUS_W-1:0] bus_addr;
    logic [DMA_BUS_W-1:0] bus_wdata;
    logic [DMA_BUS_W-1:0] bus_rdata;
    logic                 bus_ack;
    logic                 bus_err;
    logic                 busy;
    logic [7:0]           txn_count;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err, busy, txn_count
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err, busy, txn_count
    );

endinterface
`default_nettype wire

// File: rtl/dma_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : dma_resp_mem
// Description : DEPTH x 8 register storage, sync write, registered read, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_resp_mem
    import dma_bus_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_wr_en,
    input  wire logic                 i_rd_en,
    input  wire logic [AW-1:0]        i_addr,
    input  wire logic [DMA_BUS_W-1:0] i_wdata,
    output logic      [DMA_BUS_W-1:0] o_rdata
);

    logic [DMA_BUS_W-1:0] r_mem [DEPTH];
    logic [DMA_BUS_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_addr] <= i_wdata;
            end
            if (i_rd_en) begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dma_mem_responder
// Description : Byte-wide DMA bus memory target with programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_mem_responder
    import dma_bus_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dma_mem_responder_if.slave bus
);

    localparam int         c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

    dma_resp_state_e      r_state, w_state_nxt;
    logic [3:0]           r_wait_cnt, w_wait_cnt_nxt;
    logic                 r_we;
    logic [DMA_BUS_W-1:0] r_addr, r_wdata;
    logic                 w_we;
    logic [DMA_BUS_W-1:0] w_addr, w_wdata;
    logic                 w_in_range, w_enter_ack;
    logic                 r_ack, r_err, r_busy, r_rd_err;
    logic [7:0]           r_txn_count;
    logic [DMA_BUS_W-1:0] w_mem_rdata;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            DMA_RESP_IDLE: begin
                if (bus.bus_req) begin
                    w_wait_cnt_nxt = c_wait;
                    w_state_nxt    = (WAIT_CYCLES == 0) ? DMA_RESP_ACK : DMA_RESP_WAIT;
                end
            end
            DMA_RESP_WAIT: begin
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt = DMA_RESP_ACK;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            DMA_RESP_ACK:  w_state_nxt = DMA_RESP_IDLE;
            default:       w_state_nxt = DMA_RESP_IDLE;
        endcase
    end

    // With zero wait states the ACK edge is also the capture edge, so the live bus is used.
    assign w_we        = (r_state == DMA_RESP_IDLE) ? bus.bus_we    : r_we;
    assign w_addr      = (r_state == DMA_RESP_IDLE) ? bus.bus_addr  : r_addr;
    assign w_wdata     = (r_state == DMA_RESP_IDLE) ? bus.bus_wdata : r_wdata;
    assign w_in_range  = int'(w_addr) < DEPTH;
    assign w_enter_ack = (w_state_nxt == DMA_RESP_ACK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= DMA_RESP_IDLE;
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_err    <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (r_state == DMA_RESP_IDLE && bus.bus_req) begin
                r_we    <= bus.bus_we;
                r_addr  <= bus.bus_addr;
                r_wdata <= bus.bus_wdata;
            end
            r_ack  <= w_enter_ack;
            r_err  <= w_enter_ack && !w_in_range;
            r_busy <= (w_state_nxt != DMA_RESP_IDLE);
            if (w_enter_ack) begin
                r_txn_count <= r_txn_count + 8'd1;
                if (!w_we) begin
                    r_rd_err <= !w_in_range;
                end
            end
        end
    end

    dma_resp_mem #(
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_en (w_enter_ack && w_we && w_in_range),
        .i_rd_en (w_enter_ack && !w_we && w_in_range),
        .i_addr  (w_addr[c_aw-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bus.bus_rdata = r_rd_err ? DMA_ERR_RDATA : w_mem_rdata;
    assign bus.bus_ack   = r_ack;
    assign bus.bus_err   = r_err;
    assign bus.busy      = r_busy;
    assign bus.txn_count = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_mem_responder
// Description : Randomized self-checking bench, one responder at 1 wait state, one at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_mem_responder;

    localparam int c_depth  = 16;
    localparam int c_wait_a = 1;
    localparam int c_wait_b = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_mem_responder_if ifa ();
    dma_mem_responder_if ifb ();

    dma_mem_responder #(.DEPTH(c_depth), .WAIT_CYCLES(c_wait_a)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa)
    );
    dma_mem_responder #(.DEPTH(c_depth), .WAIT_CYCLES(c_wait_b)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb)
    );

    logic       req [2];
    logic       we;
    logic [7:0] addr, wdata;
    logic       ack [2], err [2], busy [2];
    logic [7:0] rdata [2], cnt [2];

    assign ifa.bus_req = req[0];  assign ifb.bus_req = req[1];
    assign ifa.bus_we = we;       assign ifb.bus_we = we;
    assign ifa.bus_addr = addr;   assign ifb.bus_addr = addr;
    assign ifa.bus_wdata = wdata; assign ifb.bus_wdata = wdata;
    assign ack[0] = ifa.bus_ack;     assign ack[1] = ifb.bus_ack;
    assign err[0] = ifa.bus_err;     assign err[1] = ifb.bus_err;
    assign busy[0] = ifa.busy;       assign busy[1] = ifb.busy;
    assign rdata[0] = ifa.bus_rdata; assign rdata[1] = ifb.bus_rdata;
    assign cnt[0] = ifa.txn_count;   assign cnt[1] = ifb.txn_count;

    // Reference model: plain memory image, completed-transfer count, last read value.
    logic [7:0] m_mem [2][c_depth];
    int         m_cnt [2];
    logic [7:0] m_rd  [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat(input int sel);
        return (sel == 0) ? c_wait_a : c_wait_b;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < c_depth; a++) m_mem[s][a] = 8'h00;
            m_cnt[s] = 0;
            m_rd[s]  = 8'h00;
        end
    endtask

    task automatic model_apply(input int sel, input logic w, input logic [7:0] a,
                               input logic [7:0] d, output logic e_err);
        e_err = (int'(a) >= c_depth);
        if (w) begin
            if (!e_err) m_mem[sel][a % c_depth] = d;
        end else begin
            m_rd[sel] = e_err ? 8'hFF : m_mem[sel][a % c_depth];
        end
        m_cnt[sel] = (m_cnt[sel] + 1) % 256;
    endtask

    // One isolated transfer; inputs are scrambled after capture to prove the latched copy is used.
    task automatic txn(input int sel, input logic w, input logic [7:0] a, input logic [7:0] d);
        int   cyc;
        logic e_err;
        req[sel] = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        check("busy_capture", busy[sel], 1);
        we = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
        req[sel] = 1'($urandom_range(0, 1));
        cyc = 0;
        while (ack[sel] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        req[sel] = 1'b0;
        model_apply(sel, w, a, d, e_err);
        check("ack_latency", cyc, lat(sel));
        check("err", err[sel], e_err);
        check("rdata", rdata[sel], m_rd[sel]);
        check("txn_count", cnt[sel], m_cnt[sel]);
        @(posedge clk); #1;
        check("ack_pulse", ack[sel], 0);
        check("busy_idle", busy[sel], 0);
    endtask

    initial begin
        logic e_err;
        int   t, last, k;
        req[0] = 1'b0; req[1] = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_ack", ack[s], 0);
            check("rst_err", err[s], 0);
            check("rst_busy", busy[s], 0);
            check("rst_rdata", rdata[s], 0);
            check("rst_count", cnt[s], 0);
        end
        rst_n = 1'b1;

        // Directed: basic write/read, out-of-range access, aliasing check
        txn(0, 1'b1, 8'd3, 8'hA5);
        txn(0, 1'b0, 8'd3, 8'h00);
        check("t1_rdata", rdata[0], 8'hA5);
        txn(0, 1'b1, 8'h20, 8'h77);
        check("t2_wr_err", err[0], 0);
        txn(0, 1'b0, 8'h20, 8'h00);
        check("t2_rd_ff", rdata[0], 8'hFF);
        txn(0, 1'b0, 8'h00, 8'h00);
        check("t2_alias", rdata[0], 8'h00);

        // Back-to-back writes with bus_req held high
        req[0] = 1'b1; we = 1'b1; addr = 8'd0; wdata = 8'($urandom);
        t = 0; last = 0; k = 0;
        while (k < 4 && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (ack[0] === 1'b1) begin
                model_apply(0, we, addr, wdata, e_err);
                check("b2b_err", err[0], e_err);
                if (k > 0) check("b2b_spacing", t - last, c_wait_a + 2);
                last = t;
                k++;
                if (k == 4) req[0] = 1'b0;
                else begin addr = 8'(k); wdata = 8'($urandom); end
            end
        end
        check("b2b_acks", k, 4);
        check("b2b_count", cnt[0], m_cnt[0]);
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) txn(0, 1'b0, 8'(a), 8'h00);

        // Zero-wait responder: write/read with inputs toggled mid-transfer
        txn(1, 1'b1, 8'd7, 8'h3C);
        txn(1, 1'b0, 8'd7, 8'h00);
        check("t5_rdata", rdata[1], 8'h3C);
        txn(1, 1'b0, 8'd200, 8'h00);
        check("t5_oor", rdata[1], 8'hFF);

        // Random mix across both responders
        for (int i = 0; i < 40; i++) begin
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 23)), 8'($urandom));
        end

        // Reset during the wait state of a write to address 5
        req[0] = 1'b1; we = 1'b1; addr = 8'd5; wdata = 8'h5A;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("t4_busy_wait", busy[0], 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_no_ack", ack[0], 0);
        check("t4_busy", busy[0], 0);
        check("t4_count", cnt[0], 0);
        rst_n = 1'b1;
        model_reset();
        txn(0, 1'b0, 8'd5, 8'h00);
        check("t4_rd5", rdata[0], 8'h00);

        // Counter wrap: already one transfer since reset, 255 more reach 256
        for (int i = 0; i < 255; i++) begin
            txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom));
        end
        check("wrap_0", cnt[0], 0);
        txn(0, 1'b1, 8'd9, 8'h12);
        check("wrap_1", cnt[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
